// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, sequencer states and the opcode-class helper.
package cu_pkg;

  localparam int N_REGS = 16;
  localparam int OP_W   = 5;

  // IR field positions (opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15])
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  localparam logic [OP_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OPC_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OPC_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OPC_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OPC_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OPC_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OPC_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    EX3    = 3'd3,
    EX4    = 3'd4,
    EX5    = 3'd5,
    EX6    = 3'd6,
    HALTED = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU3    = 3'd0,
    CL_MULDIV  = 3'd1,
    CL_UNARY   = 3'd2,
    CL_NOP     = 3'd3,
    CL_HALT    = 3'd4,
    CL_ILLEGAL = 3'd5
  } op_class_t;

  // Map an opcode onto the execution class that shapes its EX steps.
  function automatic op_class_t classify(input logic [OP_W-1:0] opc);
    op_class_t cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
      OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL: cls = CL_ALU3;
      OPC_MUL, OPC_DIV:                    cls = CL_MULDIV;
      OPC_NEG, OPC_NOT:                    cls = CL_UNARY;
      OPC_NOP:                             cls = CL_NOP;
      OPC_HALT:                            cls = CL_HALT;
      default:                             cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the sequencer (master) and the datapath (slave):
// IR/handshake inputs to the sequencer and every select/load strobe out of it.
interface control_unit_if;
  import cu_pkg::*;

  logic [31:0]       ir;
  logic              mem_rdy;
  logic              stop;
  logic [N_REGS-1:0] R_rd;
  logic [N_REGS-1:0] R_wrt;
  logic              PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out;
  logic              MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd;
  logic              IncPC, Read;
  logic [OP_W-1:0]   op_sel;
  logic              run;
  logic              illegal;

  modport master (
    input  ir, mem_rdy, stop,
    output R_rd, R_wrt, PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out,
           MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd,
           IncPC, Read, op_sel, run, illegal
  );

  modport slave (
    output ir, mem_rdy, stop,
    input  R_rd, R_wrt, PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out,
           MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd,
           IncPC, Read, op_sel, run, illegal
  );
endinterface

// File: rtl/control_unit_onehot_dec.sv
// 4-to-16 one-hot decoder with enable; all-zero when disabled.
module onehot_dec
  import cu_pkg::*;
(
  input  logic              en,
  input  logic [3:0]        idx,
  output logic [N_REGS-1:0] onehot
);

  // Select one register line, or none when the step does not touch the file.
  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot = 16'h0001 << idx;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch plus per-class execute microsteps, one
// step per clock, driving the datapath bus selects and register loads.
module control_unit
  import cu_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  control_unit_if.master bus
);

  state_t          state_r, state_s;
  logic            f1_first_r;
  logic            run_r;
  logic [OP_W-1:0] opc_s;
  logic [3:0]      ra_s, rb_s, rc_s;
  op_class_t       class_s;
  logic            last_s;
  state_t          end_s;
  logic            rd_en_s, wrt_en_s;
  logic [3:0]      rd_idx_s, wrt_idx_s;
  logic [N_REGS-1:0] rd_hot_s, wrt_hot_s;

  assign opc_s   = bus.ir[OPC_MSB:OPC_LSB];
  assign ra_s    = bus.ir[RA_LSB+3:RA_LSB];
  assign rb_s    = bus.ir[RB_LSB+3:RB_LSB];
  assign rc_s    = bus.ir[RC_LSB+3:RC_LSB];
  assign class_s = classify(opc_s);

  // State register; f1_first_r marks the first FETCH1 cycle so PC loads once.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= FETCH0;
      f1_first_r <= 1'b0;
      run_r      <= 1'b1;
    end else begin
      state_r    <= state_s;
      f1_first_r <= (state_r == FETCH0);
      run_r      <= (state_s != HALTED);
    end
  end

  // Next-state: stop is honoured only on the final step of an instruction.
  // NOP/HALT are resolved in FETCH2 from the ir value presented that cycle.
  always_comb begin
    state_s = state_r;
    last_s  = 1'b0;
    end_s   = bus.stop ? HALTED : FETCH0;
    case (state_r)
      FETCH2:  last_s = (class_s == CL_NOP);
      EX3:     last_s = (class_s == CL_ILLEGAL);
      EX4:     last_s = (class_s == CL_UNARY);
      EX5:     last_s = (class_s == CL_ALU3);
      EX6:     last_s = 1'b1;
      default: last_s = 1'b0;
    endcase
    case (state_r)
      FETCH0:  state_s = FETCH1;
      FETCH1:  state_s = bus.mem_rdy ? FETCH2 : FETCH1;
      FETCH2: begin
        if (class_s == CL_HALT) begin
          state_s = HALTED;
        end else if (last_s) begin
          state_s = end_s;
        end else begin
          state_s = EX3;
        end
      end
      EX3:     state_s = last_s ? end_s : EX4;
      EX4:     state_s = last_s ? end_s : EX5;
      EX5:     state_s = last_s ? end_s : EX6;
      EX6:     state_s = end_s;
      HALTED:  state_s = HALTED;
      default: state_s = FETCH0;
    endcase
  end

  // Moore output decode; everything except run is held low while clr is high.
  always_comb begin
    bus.PC_out = 1'b0;  bus.MDR_out = 1'b0; bus.Zhi_out = 1'b0;
    bus.Zlo_out = 1'b0; bus.HI_out = 1'b0;  bus.LO_out = 1'b0;
    bus.MAR_rd = 1'b0;  bus.PC_rd = 1'b0;   bus.MDR_rd = 1'b0;
    bus.IR_rd = 1'b0;   bus.Y_rd = 1'b0;    bus.Zlo_rd = 1'b0;
    bus.HI_rd = 1'b0;   bus.LO_rd = 1'b0;   bus.IncPC = 1'b0;
    bus.Read = 1'b0;    bus.op_sel = 5'b00000; bus.illegal = 1'b0;
    rd_en_s = 1'b0;  rd_idx_s = 4'd0;
    wrt_en_s = 1'b0; wrt_idx_s = 4'd0;
    if (clr) begin
      bus.Read = 1'b0;
    end else begin
      case (state_r)
        FETCH0: begin
          bus.PC_out = 1'b1; bus.MAR_rd = 1'b1; bus.IncPC = 1'b1; bus.Zlo_rd = 1'b1;
        end
        FETCH1: begin
          bus.Zlo_out = 1'b1; bus.PC_rd = f1_first_r; bus.Read = 1'b1; bus.MDR_rd = 1'b1;
        end
        FETCH2: begin
          bus.MDR_out = 1'b1; bus.IR_rd = 1'b1;
        end
        EX3: begin
          case (class_s)
            CL_ALU3:    begin wrt_en_s = 1'b1; wrt_idx_s = rb_s; bus.Y_rd = 1'b1; end
            CL_MULDIV:  begin wrt_en_s = 1'b1; wrt_idx_s = ra_s; bus.Y_rd = 1'b1; end
            CL_UNARY:   begin wrt_en_s = 1'b1; wrt_idx_s = rb_s; bus.op_sel = opc_s; bus.Zlo_rd = 1'b1; end
            CL_ILLEGAL: bus.illegal = 1'b1;
            default:    bus.illegal = 1'b0;
          endcase
        end
        EX4: begin
          case (class_s)
            CL_ALU3:   begin wrt_en_s = 1'b1; wrt_idx_s = rc_s; bus.op_sel = opc_s; bus.Zlo_rd = 1'b1; end
            CL_MULDIV: begin wrt_en_s = 1'b1; wrt_idx_s = rb_s; bus.op_sel = opc_s; bus.Zlo_rd = 1'b1; end
            CL_UNARY:  begin bus.Zlo_out = 1'b1; rd_en_s = 1'b1; rd_idx_s = ra_s; end
            default:   bus.Zlo_out = 1'b0;
          endcase
        end
        EX5: begin
          case (class_s)
            CL_ALU3:   begin bus.Zlo_out = 1'b1; rd_en_s = 1'b1; rd_idx_s = ra_s; end
            CL_MULDIV: begin bus.Zlo_out = 1'b1; bus.LO_rd = 1'b1; end
            default:   bus.Zlo_out = 1'b0;
          endcase
        end
        EX6: begin
          bus.Zhi_out = 1'b1; bus.HI_rd = 1'b1;
        end
        default: bus.Read = 1'b0;
      endcase
    end
  end

  onehot_dec u_rd_dec  (.en(rd_en_s),  .idx(rd_idx_s),  .onehot(rd_hot_s));
  onehot_dec u_wrt_dec (.en(wrt_en_s), .idx(wrt_idx_s), .onehot(wrt_hot_s));

  assign bus.R_rd  = rd_hot_s;
  assign bus.R_wrt = wrt_hot_s;
  assign bus.run   = run_r;

endmodule
